// File: rtl/texel_pkg.sv
// Shared definitions for the texel stream assembler: frame marker
// values, assembler FSM states and the words-per-texel helper.
package texel_pkg;

    localparam logic [31:0] FRAME_START = 32'd0;
    localparam logic [31:0] FRAME_END   = 32'd1;

    typedef enum logic {
        WAIT_SOF,
        COLLECT
    } asm_state_t;

    function automatic int words_per_texel(input int tw, input int ww);
        return (tw + ww - 1) / ww;
    endfunction

endpackage

// File: rtl/texel_fifo.sv
// Synchronous FIFO holding assembled texels; pushes are dropped when
// full and pops are ignored when empty.
// Ports: clk, rst (sync, active high), push/din, pop, full, empty,
// head (oldest entry, zero when empty).
module texel_fifo #(
    parameter int WIDTH = 168,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == OW'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + OW'(do_push) - OW'(do_pop);
        end
    end

endmodule

// File: rtl/texel_stream_assembler.sv
// Packs AHB words into texel records (first word most significant),
// honours FRAME_START/FRAME_END at texel boundaries and buffers texels.
// Ports: clk, rst; ahb_buffer/ahb_data_available in, ahb_user_read_buffer
// out; texel_buffer/texel_ready out, texel_read in; frame_done,
// frame_texels, frame_error out.
module texel_stream_assembler
    import texel_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int TEXEL_W    = 168,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAMED     = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  ahb_buffer,
    input  logic               ahb_data_available,
    output logic               ahb_user_read_buffer,
    output logic [TEXEL_W-1:0] texel_buffer,
    output logic               texel_ready,
    input  logic               texel_read,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_texels,
    output logic               frame_error
);

    localparam int WPT = words_per_texel(TEXEL_W, WORD_W);
    localparam int SRW = WPT * WORD_W;
    localparam int WCW = (WPT > 1) ? $clog2(WPT) : 1;
    localparam logic [WCW-1:0]    LAST  = WCW'(WPT - 1);
    localparam logic [WORD_W-1:0] SOF_W = WORD_W'(FRAME_START);
    localparam logic [WORD_W-1:0] EOF_W = WORD_W'(FRAME_END);
    localparam asm_state_t INIT_ST = (FRAMED != 0) ? WAIT_SOF : COLLECT;

    asm_state_t       state;
    asm_state_t       state_nx;
    logic [WCW-1:0]   word_cnt;
    logic [SRW-1:0]   sr;
    logic [SRW-1:0]   sr_nx;
    logic [CNT_W-1:0] frame_cnt;
    logic             accept;
    logic             fire;
    logic             in_col;
    logic             at_bound;
    logic             is_sof;
    logic             is_eof;
    logic             is_data;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;

    // Markers are only decoded at a texel boundary inside a frame.
    assign in_col   = (state == COLLECT);
    assign at_bound = (word_cnt == '0);
    assign is_sof   = (FRAMED != 0) && at_bound && (ahb_buffer == SOF_W);
    assign is_eof   = (FRAMED != 0) && at_bound && (ahb_buffer == EOF_W);
    assign is_data  = in_col && !is_sof && !is_eof;
    assign fire     = ahb_user_read_buffer;
    assign push     = fire && is_data && (word_cnt == LAST);
    assign sr_nx    = SRW'({sr, ahb_buffer});

    always_ff @(posedge clk) begin
        if (rst) state <= INIT_ST;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (fire) begin
            unique case (state)
                WAIT_SOF: if (ahb_buffer == SOF_W) state_nx = COLLECT;
                COLLECT:  if (is_eof) state_nx = WAIT_SOF;
                default:  state_nx = INIT_ST;
            endcase
        end
    end

    // The final word of a texel stalls while the FIFO is full, even if
    // a pop happens in the same cycle.
    always_comb begin
        accept = !(in_col && (word_cnt == LAST) && fifo_full);
        ahb_user_read_buffer = ahb_data_available && accept && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt     <= '0;
            sr           <= '0;
            frame_cnt    <= '0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
            frame_texels <= '0;
        end else begin
            frame_done  <= fire && in_col && is_eof;
            frame_error <= fire && in_col && is_sof;
            if (fire && !in_col && (ahb_buffer == SOF_W)) begin
                frame_cnt <= '0;
            end
            if (fire && in_col && is_sof) begin
                frame_cnt <= '0;
            end
            if (fire && in_col && is_eof) begin
                frame_texels <= frame_cnt;
            end
            if (fire && is_data) begin
                sr <= sr_nx;
                if (word_cnt == LAST) begin
                    word_cnt <= '0;
                    if (!(&frame_cnt)) frame_cnt <= frame_cnt + CNT_W'(1);
                end else begin
                    word_cnt <= word_cnt + WCW'(1);
                end
            end
        end
    end

    texel_fifo #(
        .WIDTH (TEXEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sr_nx[TEXEL_W-1:0]),
        .pop   (texel_read),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (texel_buffer)
    );

    assign texel_ready = !fifo_empty;

endmodule

// File: tb/tb_texel_stream_assembler.sv
// Self-checking bench for texel_stream_assembler: directed scenarios plus
// a randomized run checked against a queue-based reference model.
module tb_texel_stream_assembler;

    localparam int WORD_W     = 32;
    localparam int TEXEL_W    = 168;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
    localparam int WPT        = 6;

    localparam logic [TEXEL_W-1:0] T2 = {8'h00, 32'h77665544,
        32'hBBAA9988, 32'hFFEEDDCC, 32'h76543210, 32'hFEDBCA98};
    localparam logic [TEXEL_W-1:0] TM = {8'h00, 32'h0, 32'h1,
        32'h0, 32'h1, 32'h0};

    logic               tb_clk = 1'b0;
    logic               rst = 1'b1;
    logic [WORD_W-1:0]  ahb_buffer = '0;
    logic               ahb_data_available = 1'b0;
    logic               ahb_user_read_buffer;
    logic [TEXEL_W-1:0] texel_buffer;
    logic               texel_ready;
    logic               texel_read = 1'b0;
    logic               frame_done;
    logic [CNT_W-1:0]   frame_texels;
    logic               frame_error;

    logic [31:0] W [6] = '{32'h33221100, 32'h77665544, 32'hBBAA9988,
                           32'hFFEEDDCC, 32'h76543210, 32'hFEDBCA98};

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit                 m_inframe;
    int                 m_cnt;
    logic [31:0]        m_words [6];
    logic [TEXEL_W-1:0] m_q [$];
    int                 m_fcnt;
    logic [CNT_W-1:0]   m_texels;
    bit                 m_done;
    bit                 m_err;
    bit                 obs_rb;
    bit                 exp_rb;

    always #5 tb_clk = ~tb_clk;

    texel_stream_assembler #(
        .WORD_W     (WORD_W),
        .TEXEL_W    (TEXEL_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FRAMED     (1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                  (tb_clk),
        .rst                  (rst),
        .ahb_buffer           (ahb_buffer),
        .ahb_data_available   (ahb_data_available),
        .ahb_user_read_buffer (ahb_user_read_buffer),
        .texel_buffer         (texel_buffer),
        .texel_ready          (texel_ready),
        .texel_read           (texel_read),
        .frame_done           (frame_done),
        .frame_texels         (frame_texels),
        .frame_error          (frame_error)
    );

    function automatic bit model_accept();
        return !(m_inframe && m_cnt == WPT - 1 && m_q.size() == FIFO_DEPTH);
    endfunction

    function automatic logic [TEXEL_W-1:0] model_head();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    task automatic model_edge(input bit r, input bit av,
                              input logic [31:0] w, input bit rd);
        logic [191:0] bits;
        bit take;
        if (r) begin
            m_inframe = 0;
            m_cnt = 0;
            m_q.delete();
            m_fcnt = 0;
            m_texels = '0;
            m_done = 0;
            m_err = 0;
            return;
        end
        take = av && model_accept();
        m_done = 0;
        m_err = 0;
        if (rd && m_q.size() != 0) void'(m_q.pop_front());
        if (take) begin
            if (!m_inframe) begin
                if (w == 32'd0) begin
                    m_inframe = 1;
                    m_fcnt = 0;
                end
            end else if (m_cnt == 0 && w == 32'd1) begin
                m_done = 1;
                m_texels = CNT_W'(m_fcnt);
                m_inframe = 0;
            end else if (m_cnt == 0 && w == 32'd0) begin
                m_err = 1;
                m_fcnt = 0;
            end else begin
                m_words[m_cnt] = w;
                m_cnt++;
                if (m_cnt == WPT) begin
                    bits = '0;
                    for (int i = 0; i < WPT; i++)
                        bits = (bits << 32) | 192'(m_words[i]);
                    m_q.push_back(bits[TEXEL_W-1:0]);
                    m_cnt = 0;
                    if (m_fcnt < 65535) m_fcnt++;
                end
            end
        end
    endtask

    // One clock: drive inputs, sample the combinational handshake at the
    // falling edge, advance the model at the rising edge, return 1 later.
    task automatic cycle(input bit r, input bit av,
                         input logic [31:0] w, input bit rd);
        rst = r;
        ahb_data_available = av;
        ahb_buffer = w;
        texel_read = rd;
        @(negedge tb_clk);
        obs_rb = ahb_user_read_buffer;
        exp_rb = av && !r && model_accept();
        @(posedge tb_clk);
        model_edge(r, av, w, rd);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 32'h0, 0);
            vectors++;
            if (obs_rb !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_rb: got %0b want 0", obs_rb);
            end
        end
        vectors++;
        if (texel_ready !== 1'b0 || texel_buffer !== '0) begin
            miscompares++;
            $display("FAIL reset_texel: ready %0b buf %h want 0/0",
                     texel_ready, texel_buffer);
        end
        vectors++;
        if (frame_done !== 1'b0 || frame_error !== 1'b0
            || frame_texels !== '0) begin
            miscompares++;
            $display("FAIL reset_frame: done %0b err %0b cnt %0d want 0",
                     frame_done, frame_error, frame_texels);
        end
        cycle(0, 0, 32'h0, 0);
    endtask

    task automatic test_frame();
        logic [31:0] seq [8];
        seq[0] = 32'd0;
        for (int i = 0; i < 6; i++) seq[i+1] = W[i];
        seq[7] = 32'd1;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, seq[i], 0);
            vectors++;
            if (obs_rb !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_rb[%0d]: got %0b want 1", i, obs_rb);
            end
            if (i == 6) begin
                vectors++;
                if (texel_ready !== 1'b1 || texel_buffer !== T2) begin
                    miscompares++;
                    $display("FAIL frame_texel: ready %0b buf %h want 1 %h",
                             texel_ready, texel_buffer, T2);
                end
            end
        end
        vectors++;
        if (frame_done !== 1'b1 || frame_texels !== 16'd1) begin
            miscompares++;
            $display("FAIL frame_done: done %0b cnt %0d want 1 1",
                     frame_done, frame_texels);
        end
        cycle(0, 0, 32'h0, 1);
        vectors++;
        if (frame_done !== 1'b0 || texel_ready !== 1'b0
            || texel_buffer !== '0) begin
            miscompares++;
            $display("FAIL frame_after: done %0b ready %0b buf %h want 0",
                     frame_done, texel_ready, texel_buffer);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        cycle(0, 1, 32'd0, 0);
        for (int i = 0; i < 29; i++) begin
            w = $urandom | 32'h100;
            cycle(0, 1, w, 0);
            vectors++;
            if (obs_rb !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_rb[%0d]: got %0b want 1", i, obs_rb);
            end
        end
        w = $urandom | 32'h100;
        cycle(0, 1, w, 0);
        vectors++;
        if (obs_rb !== 1'b0 || texel_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stall: rb %0b ready %0b want 0 1",
                     obs_rb, texel_ready);
        end
        cycle(0, 1, w, 1);
        vectors++;
        if (obs_rb !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_pop_rb: got %0b want 0", obs_rb);
        end
        cycle(0, 1, w, 0);
        vectors++;
        if (obs_rb !== 1'b1 || texel_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_resume: rb %0b ready %0b want 1 1",
                     obs_rb, texel_ready);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            vectors++;
            if (texel_buffer !== model_head() || texel_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: got %h want %h",
                         i, texel_buffer, model_head());
            end
            cycle(0, 0, 32'h0, 1);
        end
        vectors++;
        if (texel_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_empty: ready %0b want 0", texel_ready);
        end
        cycle(0, 1, 32'd1, 0);
        vectors++;
        if (frame_done !== 1'b1 || frame_texels !== 16'd5) begin
            miscompares++;
            $display("FAIL bp_count: done %0b cnt %0d want 1 5",
                     frame_done, frame_texels);
        end
    endtask

    task automatic test_marker_as_data();
        logic [31:0] seq [7];
        int pulses = 0;
        seq = '{32'd0, W[0], 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
        for (int i = 0; i < 7; i++) begin
            cycle(0, 1, seq[i], 0);
            if (frame_done || frame_error) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL marker_pulses: got %0d want 0", pulses);
        end
        vectors++;
        if (texel_ready !== 1'b1 || texel_buffer !== TM) begin
            miscompares++;
            $display("FAIL marker_texel: got %h want %h", texel_buffer, TM);
        end
        cycle(0, 1, 32'd1, 0);
        vectors++;
        if (frame_done !== 1'b1 || frame_texels !== 16'd1) begin
            miscompares++;
            $display("FAIL marker_end: done %0b cnt %0d want 1 1",
                     frame_done, frame_texels);
        end
    endtask

    task automatic test_framing_error();
        logic [31:0] seq [15];
        int errs = 0;
        seq[0] = 32'd0;
        seq[7] = 32'd0;
        seq[14] = 32'd1;
        for (int i = 0; i < 6; i++) begin
            seq[i+1] = W[i];
            seq[i+8] = W[i];
        end
        for (int i = 0; i < 15; i++) begin
            cycle(0, 1, seq[i], 0);
            if (frame_error) errs++;
            vectors++;
            if (frame_error !== (i == 7)) begin
                miscompares++;
                $display("FAIL ferr_pulse[%0d]: got %0b want %0b",
                         i, frame_error, i == 7);
            end
        end
        vectors++;
        if (errs != 1 || frame_done !== 1'b1 || frame_texels !== 16'd1) begin
            miscompares++;
            $display("FAIL ferr_end: errs %0d done %0b cnt %0d want 1 1 1",
                     errs, frame_done, frame_texels);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] seq [4];
        seq = '{32'd0, W[0], W[1], W[2]};
        for (int i = 0; i < 4; i++) cycle(0, 1, seq[i], 0);
        cycle(1, 0, 32'h0, 0);
        vectors++;
        if (texel_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_flush: ready %0b want 0", texel_ready);
        end
        cycle(0, 1, 32'd0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, W[i], 0);
        vectors++;
        if (texel_ready !== 1'b1 || texel_buffer !== T2) begin
            miscompares++;
            $display("FAIL rmid_texel: got %h want %h", texel_buffer, T2);
        end
        cycle(0, 0, 32'h0, 1);
        vectors++;
        if (texel_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_single: ready %0b want 0", texel_ready);
        end
    endtask

    task automatic test_random();
        bit r;
        bit av;
        bit rd;
        int sel;
        logic [31:0] w;
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 149) == 0);
            av = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            w = (sel == 0) ? 32'd0 : (sel == 1) ? 32'd1 : $urandom;
            rd = ($urandom_range(0, 2) == 0);
            cycle(r, av, w, rd);
            vectors++;
            if (obs_rb !== exp_rb) begin
                miscompares++;
                $display("FAIL rnd_rb[%0d]: got %0b want %0b",
                         n, obs_rb, exp_rb);
            end
            vectors++;
            if (texel_ready !== (m_q.size() != 0)
                || texel_buffer !== model_head()) begin
                miscompares++;
                $display("FAIL rnd_texel[%0d]: got %0b %h want %h",
                         n, texel_ready, texel_buffer, model_head());
            end
            vectors++;
            if (frame_done !== m_done || frame_error !== m_err
                || frame_texels !== m_texels) begin
                miscompares++;
                $display("FAIL rnd_frame[%0d]: got %0b %0b %0d want %0b %0b %0d",
                         n, frame_done, frame_error, frame_texels,
                         m_done, m_err, m_texels);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_marker_as_data();
        test_framing_error();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
